// File: rtl/mem_lsu_bus.sv
// MEM-stage load/store unit: one outstanding big-endian bus access per op.
// Define LSU_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES without ack.
`timescale 1ns/1ps
module mem_lsu_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TMO_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        except_misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ABORT  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_tmo_w_bad
    $error("TMO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_q, load_d;
  logic        ld_q, ld_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

`ifdef LSU_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q + TMO_W'(1)) == TMO_LIM;
`endif

  logic       is_mem, is_load, is_sgn, mis;
  logic [1:0] size;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_mem  = 1'b1;
    is_load = 1'b0;
    is_sgn  = 1'b0;
    size    = SZ_W;
    unique case (mem_aluop)
      OP_LB:  begin is_load = 1'b1; is_sgn = 1'b1; size = SZ_B; end
      OP_LBU: begin is_load = 1'b1; size = SZ_B; end
      OP_LH:  begin is_load = 1'b1; is_sgn = 1'b1; size = SZ_H; end
      OP_LHU: begin is_load = 1'b1; size = SZ_H; end
      OP_LW:  is_load = 1'b1;
      OP_SB:  size = SZ_B;
      OP_SH:  size = SZ_H;
      OP_SW:  size = SZ_W;
      default: is_mem = 1'b0;
    endcase
  end

  assign mis = is_mem &
    (((size == SZ_H) & mem_mem_addr[0]) |
     ((size == SZ_W) & (|mem_mem_addr[1:0])));

  // Lane 3 (data[31:24]) holds the lowest address byte.
  always_comb begin
    sel_new   = 4'b1111;
    wdata_new = mem_reg2;
    unique case (size)
      SZ_B: begin
        sel_new   = 4'b1000 >> mem_mem_addr[1:0];
        wdata_new = {4{mem_reg2[7:0]}};
      end
      SZ_H: begin
        sel_new   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_new = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v = bus_rdata_i[31:24];
    unique case (off_q)
      2'd1: byte_v = bus_rdata_i[23:16];
      2'd2: byte_v = bus_rdata_i[15:8];
      2'd3: byte_v = bus_rdata_i[7:0];
      default: ;
    endcase
    half_v = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    ext = bus_rdata_i;
    unique case (size_q)
      SZ_B: ext = {{24{sgn_q & byte_v[7]}}, byte_v};
      SZ_H: ext = {{16{sgn_q & half_v[15]}}, half_v};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    load_d      = load_q;
    ld_d        = ld_q;
    sgn_d       = sgn_q;
    size_d      = size_q;
    off_d       = off_q;
`ifdef LSU_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif
    wd_o              = '0;
    wreg_o            = 1'b0;
    wdata_o           = '0;
    stallreq_o        = 1'b0;
    except_misalign_o = mis;
    unique case (state_q)
      S_IDLE: begin
        wd_o = mem_wd;
        if (!is_mem) begin
          wreg_o  = mem_wreg;
          wdata_o = mem_wdata;
        end else if (!mis && !flush) begin
          stallreq_o  = 1'b1;
          state_d     = S_ACCESS;
          bus_req_d   = 1'b1;
          bus_we_d    = !is_load;
          bus_addr_d  = {mem_mem_addr[31:2], 2'b00};
          bus_sel_d   = sel_new;
          bus_wdata_d = wdata_new;
          ld_d        = is_load;
          sgn_d       = is_sgn;
          size_d      = size;
          off_d       = mem_mem_addr[1:0];
`ifdef LSU_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      S_ACCESS: begin
        stallreq_o = 1'b1;
        wd_o       = mem_wd;
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (ld_q) load_d = ext;
          end
        end else if (flush) begin
          state_d = S_ABORT;
`ifdef LSU_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_hit) begin
            bus_req_d = 1'b0;
            state_d   = S_DONE;
            load_d    = '0;
            err_d     = 1'b1;
          end
        end
`endif
      end
      S_ABORT: begin
        stallreq_o = flush ? 1'b0 : is_mem;
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          state_d   = S_IDLE;
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_hit) begin
            bus_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
`endif
      end
      S_DONE: begin
        wd_o    = mem_wd;
        wreg_o  = ld_q & mem_wreg;
        wdata_o = load_q;
        if (!stall[4] || flush) begin
          state_d = S_IDLE;
`ifdef LSU_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      wd_o              = '0;
      wreg_o            = 1'b0;
      wdata_o           = '0;
      stallreq_o        = 1'b0;
      except_misalign_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      load_q      <= '0;
      ld_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= SZ_B;
      off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      load_q      <= load_d;
      ld_q        <= ld_d;
      sgn_q       <= sgn_d;
      size_q      <= size_d;
      off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

`ifdef LSU_TIMEOUT_EN
  assign bus_err_o = !rst && (state_q == S_DONE) && err_q;
`else
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu_bus.sv
// Directed self-checking bench for mem_lsu_bus.
// Inputs change at posedge+2, outputs sampled at posedge+3.
`timescale 1ns/1ps
module tb_mem_lsu_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        except_misalign_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_chk = 0;
  int n_fail = 0;
  int hi;

  always #5 clk = ~clk;

  mem_lsu_bus #(.TIMEOUT_CYCLES(4), .TMO_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .except_misalign_o(except_misalign_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic nop;
    mem_aluop = 8'h00; mem_wreg = 1'b0; mem_wd = '0;
    mem_wdata = '0; mem_mem_addr = '0; mem_reg2 = '0;
    flush = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0; stall = '0;
  endtask

  task automatic test_reset;
    nop;
    rst = 1'b1;
    mem_aluop = 8'h21; mem_wreg = 1'b1; mem_wd = 5'd5; mem_wdata = 32'h1234;
    tick; tick; #1;
    n_chk++; if (wreg_o !== 1'b0) begin n_fail++; $display("FAIL rst_wreg: got %b want 0", wreg_o); end
    n_chk++; if (wd_o !== 5'd0) begin n_fail++; $display("FAIL rst_wd: got %h want 0", wd_o); end
    n_chk++; if (wdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", wdata_o); end
    n_chk++; if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== '0) begin n_fail++; $display("FAIL rst_bus: got req %b sel %b addr %h want all 0", bus_req_o, bus_sel_o, bus_addr_o); end
    mem_aluop = 8'hE3; mem_mem_addr = 32'h301;
    tick; #1;
    n_chk++; if ({except_misalign_o, stallreq_o, bus_err_o} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {except_misalign_o, stallreq_o, bus_err_o}); end
    rst = 1'b0;
    nop;
  endtask

  task automatic test_passthrough;
    mem_aluop = 8'h21; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
    #1;
    n_chk++; if (wd_o !== 5'd5) begin n_fail++; $display("FAIL pass_wd: got %h want 05", wd_o); end
    n_chk++; if (wdata_o !== 32'h1234) begin n_fail++; $display("FAIL pass_wdata: got %h want 00001234", wdata_o); end
    n_chk++; if (wreg_o !== 1'b1) begin n_fail++; $display("FAIL pass_wreg: got %b want 1", wreg_o); end
    n_chk++; if ({stallreq_o, bus_req_o, except_misalign_o} !== 3'b000) begin n_fail++; $display("FAIL pass_flags: got %b want 000", {stallreq_o, bus_req_o, except_misalign_o}); end
    tick;
    mem_wd = 5'd9; mem_wdata = 32'hCAFE0001;
    #1;
    n_chk++; if ({wd_o, wdata_o} !== {5'd9, 32'hCAFE0001}) begin n_fail++; $display("FAIL pass_next: got %h/%h want 09/cafe0001", wd_o, wdata_o); end
    n_chk++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL pass_noreq: got %b want 0", bus_req_o); end
    nop;
  endtask

  task automatic test_lb;
    hi = 0;
    mem_aluop = 8'hE0; mem_mem_addr = 32'h103; mem_wd = 5'd7; mem_wreg = 1'b1;
    #1;
    hi += int'(stallreq_o);
    n_chk++; if ({stallreq_o, wreg_o, bus_req_o} !== 3'b100) begin n_fail++; $display("FAIL lb_issue: got stall/wreg/req %b want 100", {stallreq_o, wreg_o, bus_req_o}); end
    tick; #1;
    hi += int'(stallreq_o);
    n_chk++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL lb_req: got %b want 1", bus_req_o); end
    n_chk++; if (bus_sel_o !== 4'b0001) begin n_fail++; $display("FAIL lb_sel: got %b want 0001", bus_sel_o); end
    n_chk++; if (bus_addr_o !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", bus_addr_o); end
    n_chk++; if (bus_we_o !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b want 0", bus_we_o); end
    tick;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h000000F0;
    #1;
    hi += int'(stallreq_o);
    n_chk++; if ({bus_req_o, bus_sel_o, wreg_o} !== {1'b1, 4'b0001, 1'b0}) begin n_fail++; $display("FAIL lb_hold: got req %b sel %b wreg %b want 1 0001 0", bus_req_o, bus_sel_o, wreg_o); end
    tick;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    #1;
    hi += int'(stallreq_o);
    n_chk++; if (wdata_o !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_data: got %h want fffffff0", wdata_o); end
    n_chk++; if ({wd_o, wreg_o, stallreq_o, bus_req_o, bus_err_o} !== {5'd7, 4'b1000}) begin n_fail++; $display("FAIL lb_done: got wd %h wreg %b stall %b req %b err %b", wd_o, wreg_o, stallreq_o, bus_req_o, bus_err_o); end
    n_chk++; if (hi !== 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 3", hi); end
    stall = 6'b010000;
    tick; #1;
    n_chk++; if ({wreg_o, stallreq_o, wdata_o} !== {2'b10, 32'hFFFFFFF0}) begin n_fail++; $display("FAIL lb_done_hold: got wreg %b stall %b data %h", wreg_o, stallreq_o, wdata_o); end
    stall = '0;
    tick;
    nop;
    mem_aluop = 8'h21; mem_wreg = 1'b1; mem_wdata = 32'h55;
    #1;
    n_chk++; if ({bus_req_o, wdata_o} !== {1'b0, 32'h55}) begin n_fail++; $display("FAIL lb_idle: got req %b data %h want 0 00000055", bus_req_o, wdata_o); end
    nop;
  endtask

  task automatic test_sh;
    hi = 0;
    mem_aluop = 8'hE9; mem_mem_addr = 32'h202; mem_reg2 = 32'hAAAABEEF;
    #1;
    hi += int'(stallreq_o);
    tick;
    bus_ack_i = 1'b1;
    #1;
    hi += int'(stallreq_o);
    n_chk++; if (bus_we_o !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", bus_we_o); end
    n_chk++; if (bus_sel_o !== 4'b0011) begin n_fail++; $display("FAIL sh_sel: got %b want 0011", bus_sel_o); end
    n_chk++; if (bus_wdata_o !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", bus_wdata_o); end
    n_chk++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL sh_addr: got req %b addr %h want 1 00000200", bus_req_o, bus_addr_o); end
    tick;
    bus_ack_i = 1'b0;
    #1;
    hi += int'(stallreq_o);
    n_chk++; if ({wreg_o, stallreq_o, bus_req_o} !== 3'b000) begin n_fail++; $display("FAIL sh_done: got wreg/stall/req %b want 000", {wreg_o, stallreq_o, bus_req_o}); end
    n_chk++; if (hi !== 2) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d want 2", hi); end
    tick;
    nop;
  endtask

  task automatic test_misalign;
    mem_aluop = 8'hE3; mem_mem_addr = 32'h301; mem_wreg = 1'b1; mem_wd = 5'd4;
    #1;
    n_chk++; if ({except_misalign_o, stallreq_o, wreg_o} !== 3'b100) begin n_fail++; $display("FAIL mis_lw: got exc/stall/wreg %b want 100", {except_misalign_o, stallreq_o, wreg_o}); end
    tick; #1;
    n_chk++; if ({bus_req_o, except_misalign_o} !== 2'b01) begin n_fail++; $display("FAIL mis_nobus: got req/exc %b want 01", {bus_req_o, except_misalign_o}); end
    mem_aluop = 8'hE1; mem_mem_addr = 32'h101;
    #1;
    n_chk++; if ({except_misalign_o, stallreq_o} !== 2'b10) begin n_fail++; $display("FAIL mis_lh: got exc/stall %b want 10", {except_misalign_o, stallreq_o}); end
    mem_aluop = 8'hEB; mem_mem_addr = 32'h302;
    #1;
    n_chk++; if ({except_misalign_o, stallreq_o} !== 2'b10) begin n_fail++; $display("FAIL mis_sw: got exc/stall %b want 10", {except_misalign_o, stallreq_o}); end
    mem_aluop = 8'hE1; mem_mem_addr = 32'h102;
    #1;
    n_chk++; if ({except_misalign_o, stallreq_o} !== 2'b01) begin n_fail++; $display("FAIL mis_lh_ok: got exc/stall %b want 01", {except_misalign_o, stallreq_o}); end
    nop;
  endtask

  task automatic test_flush;
    mem_aluop = 8'hE3; mem_mem_addr = 32'h304; mem_wreg = 1'b1; mem_wd = 5'd3;
    flush = 1'b1;
    #1;
    n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL fl_idle_stall: got %b want 0", stallreq_o); end
    tick; #1;
    n_chk++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL fl_idle_noreq: got %b want 0", bus_req_o); end
    flush = 1'b0;
    tick; #1;
    n_chk++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h304}) begin n_fail++; $display("FAIL fl_access: got req %b addr %h", bus_req_o, bus_addr_o); end
    flush = 1'b1;
    tick; #1;
    n_chk++; if ({stallreq_o, bus_req_o, wreg_o} !== 3'b010) begin n_fail++; $display("FAIL fl_abort: got stall/req/wreg %b want 010", {stallreq_o, bus_req_o, wreg_o}); end
    flush = 1'b0; mem_aluop = 8'h00; mem_wreg = 1'b0;
    tick; #1;
    n_chk++; if ({stallreq_o, bus_req_o} !== 2'b01) begin n_fail++; $display("FAIL fl_abort_nop: got stall/req %b want 01", {stallreq_o, bus_req_o}); end
    mem_aluop = 8'hE3; mem_mem_addr = 32'h400; mem_wreg = 1'b1;
    tick; #1;
    n_chk++; if ({stallreq_o, bus_req_o, wreg_o} !== 3'b110) begin n_fail++; $display("FAIL fl_abort_op: got stall/req/wreg %b want 110", {stallreq_o, bus_req_o, wreg_o}); end
    bus_ack_i = 1'b1;
    tick;
    nop;
    #1;
    n_chk++; if ({bus_req_o, wreg_o, stallreq_o} !== 3'b000) begin n_fail++; $display("FAIL fl_end: got req/wreg/stall %b want 000", {bus_req_o, wreg_o, stallreq_o}); end
  endtask

  localparam int NB = 7;
  localparam logic [7:0]  T_OP  [NB] = '{8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE0, 8'hE8, 8'hEB};
  localparam logic [31:0] T_AD  [NB] = '{32'h101, 32'h100, 32'h002, 32'h008, 32'h001, 32'h012, 32'h010};
  localparam logic [31:0] T_RD  [NB] = '{32'h00800000, 32'h80010000, 32'h1234F00D, 32'hDEADBEEF, 32'h007F0000, 32'h0, 32'h0};
  localparam logic [31:0] T_R2  [NB] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000000AB, 32'h11223344};
  localparam logic [3:0]  T_SEL [NB] = '{4'b0100, 4'b1100, 4'b0011, 4'b1111, 4'b0100, 4'b0010, 4'b1111};
  localparam logic [31:0] T_BA  [NB] = '{32'h100, 32'h100, 32'h000, 32'h008, 32'h000, 32'h010, 32'h010};
  localparam logic [31:0] T_EXP [NB] = '{32'h80, 32'hFFFF8001, 32'h0000F00D, 32'hDEADBEEF, 32'h7F, 32'hABABABAB, 32'h11223344};
  localparam logic        T_ST  [NB] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_back_to_back;
    for (int i = 0; i < NB; i++) begin
      mem_aluop = T_OP[i]; mem_mem_addr = T_AD[i]; mem_reg2 = T_R2[i];
      mem_wreg = 1'b1; mem_wd = 5'(i + 1);
      tick;
      bus_ack_i = 1'b1; bus_rdata_i = T_RD[i];
      #1;
      n_chk++; if ({bus_sel_o, bus_addr_o, bus_we_o} !== {T_SEL[i], T_BA[i], T_ST[i]}) begin n_fail++; $display("FAIL b2b_bus[%0d]: got sel %b addr %h we %b want %b %h %b", i, bus_sel_o, bus_addr_o, bus_we_o, T_SEL[i], T_BA[i], T_ST[i]); end
      if (T_ST[i]) begin
        n_chk++; if (bus_wdata_o !== T_EXP[i]) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, bus_wdata_o, T_EXP[i]); end
      end
      tick;
      bus_ack_i = 1'b0; bus_rdata_i = '0;
      #1;
      n_chk++; if (wreg_o !== !T_ST[i]) begin n_fail++; $display("FAIL b2b_wreg[%0d]: got %b want %b", i, wreg_o, !T_ST[i]); end
      if (!T_ST[i]) begin
        n_chk++; if ({wd_o, wdata_o} !== {5'(i + 1), T_EXP[i]}) begin n_fail++; $display("FAIL b2b_load[%0d]: got %h/%h want %h/%h", i, wd_o, wdata_o, 5'(i + 1), T_EXP[i]); end
      end
      tick;
    end
    nop;
  endtask

  task automatic test_reset_mid;
    mem_aluop = 8'hE3; mem_mem_addr = 32'h500; mem_wreg = 1'b1;
    tick; #1;
    n_chk++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", bus_req_o); end
    rst = 1'b1;
    tick; #1;
    n_chk++; if ({bus_req_o, stallreq_o, wreg_o} !== 3'b000) begin n_fail++; $display("FAIL rm_drop: got req/stall/wreg %b want 000", {bus_req_o, stallreq_o, wreg_o}); end
    rst = 1'b0;
    nop;
    mem_aluop = 8'h21; mem_wreg = 1'b1; mem_wdata = 32'h77;
    tick; #1;
    n_chk++; if ({bus_req_o, wdata_o} !== {1'b0, 32'h77}) begin n_fail++; $display("FAIL rm_idle: got req %b data %h want 0 00000077", bus_req_o, wdata_o); end
    nop;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    mem_aluop = 8'hE5; mem_mem_addr = 32'h006; mem_wreg = 1'b1; mem_wd = 5'd2;
    for (int c = 0; c < 4; c++) begin
      tick; #1;
      n_chk++; if ({bus_req_o, stallreq_o} !== 2'b11) begin n_fail++; $display("FAIL tmo_wait[%0d]: got req/stall %b want 11", c, {bus_req_o, stallreq_o}); end
    end
    tick; #1;
    n_chk++; if ({bus_req_o, bus_err_o, stallreq_o} !== 3'b010) begin n_fail++; $display("FAIL tmo_done: got req/err/stall %b want 010", {bus_req_o, bus_err_o, stallreq_o}); end
    n_chk++; if ({wreg_o, wdata_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL tmo_data: got wreg %b data %h want 1 0", wreg_o, wdata_o); end
    tick;
    nop;
    #1;
    n_chk++; if (bus_err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", bus_err_o); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    nop;
    test_reset;
    test_passthrough;
    test_lb;
    test_sh;
    test_misalign;
    test_flush;
    test_back_to_back;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
